// File: rtl/display_button_scanner.sv
// Scans the display board push buttons through the PISO shift chain, debounces each bit
// and reports pressed state. Define DISPLAY_BUTTON_IRQ_EN to add a latched press interrupt.
module display_button_scanner #(
  parameter int CLK_DIV        = 25,
  parameter int NUM_BITS       = 16,
  parameter int SCAN_INTERVAL  = 50000,
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic                clk,
  input  logic                reset,
  output logic                shift_clkin,
  output logic                shift_load_n,
  input  logic                shift_out,
  output logic [NUM_BITS-1:0] buttons,
  output logic                buttons_changed,
  output logic                scan_done,
  output logic [NUM_BITS-1:0] raw_scan
`ifdef DISPLAY_BUTTON_IRQ_EN
  ,
  output logic                irq,
  input  logic                irq_ack
`endif
);

  localparam int IW = $clog2(SCAN_INTERVAL);
  localparam logic [IW-1:0] INT_LAST = IW'(SCAN_INTERVAL - 1);
  localparam logic [7:0]    DIV_LAST = 8'(CLK_DIV - 1);
  localparam logic [4:0]    BIT_LAST = 5'(NUM_BITS - 1);
  localparam logic [3:0]    DB_LAST  = 4'(DEBOUNCE_SCANS - 1);

  typedef enum logic [2:0] {IDLE, LOAD, SETTLE, SAMPLE, HIGH, LOW, DONE} state_t;

  state_t              state;
  logic [IW-1:0]       interval_cnt;
  logic                wrap;
  logic [7:0]          div_cnt;
  logic                div_last;
  logic [4:0]          bit_cnt;
  logic [1:0]          sync_q;
  logic [NUM_BITS-1:0] acc;
  logic [NUM_BITS-1:0] acc_shifted;
  logic [NUM_BITS-1:0] raw_now;
  logic [NUM_BITS-1:0] buttons_next;
  logic [NUM_BITS-1:0] differ;
  logic [NUM_BITS-1:0] db_hit;
  logic [3:0]          db_cnt  [NUM_BITS];
  logic [3:0]          db_next [NUM_BITS];

  assign wrap     = (interval_cnt == INT_LAST);
  assign div_last = (div_cnt == DIV_LAST);
  assign raw_now  = ~acc;

  // First sampled bit ends up in the MSB after NUM_BITS shifts.
  generate
    if (NUM_BITS > 1) begin : g_shift
      assign acc_shifted = {acc[NUM_BITS-2:0], sync_q[1]};
    end else begin : g_shift1
      assign acc_shifted = sync_q[1];
    end
  endgenerate

  genvar gi;
  generate
    for (gi = 0; gi < NUM_BITS; gi++) begin : g_db
      assign differ[gi]       = raw_now[gi] ^ buttons[gi];
      assign db_hit[gi]       = differ[gi] && (db_cnt[gi] == DB_LAST);
      assign buttons_next[gi] = db_hit[gi] ? raw_now[gi] : buttons[gi];
      assign db_next[gi]      = (!differ[gi] || db_hit[gi]) ? 4'd0 : db_cnt[gi] + 4'd1;
    end
  endgenerate

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      interval_cnt <= '0;
      sync_q       <= 2'b11;
    end else begin
      interval_cnt <= wrap ? '0 : interval_cnt + IW'(1);
      sync_q       <= {sync_q[0], shift_out};
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state           <= IDLE;
      div_cnt         <= '0;
      bit_cnt         <= '0;
      acc             <= '0;
      shift_clkin     <= 1'b0;
      shift_load_n    <= 1'b1;
      buttons         <= '0;
      raw_scan        <= '0;
      buttons_changed <= 1'b0;
      scan_done       <= 1'b0;
      for (int i = 0; i < NUM_BITS; i++) db_cnt[i] <= '0;
    end else begin
      scan_done       <= 1'b0;
      buttons_changed <= 1'b0;
      case (state)
        IDLE: begin
          // Wraps seen outside IDLE are simply missed, so scans never overlap.
          if (wrap) begin
            state        <= LOAD;
            shift_load_n <= 1'b0;
            div_cnt      <= '0;
          end
        end
        LOAD: begin
          if (div_last) begin
            state        <= SETTLE;
            shift_load_n <= 1'b1;
            div_cnt      <= '0;
          end else begin
            div_cnt <= div_cnt + 8'd1;
          end
        end
        SETTLE: begin
          if (div_last) begin
            state   <= SAMPLE;
            bit_cnt <= '0;
          end else begin
            div_cnt <= div_cnt + 8'd1;
          end
        end
        SAMPLE: begin
          acc <= acc_shifted;
          if (bit_cnt == BIT_LAST) begin
            state <= DONE;
          end else begin
            state       <= HIGH;
            shift_clkin <= 1'b1;
            div_cnt     <= '0;
          end
        end
        HIGH: begin
          if (div_last) begin
            state       <= LOW;
            shift_clkin <= 1'b0;
            div_cnt     <= '0;
          end else begin
            div_cnt <= div_cnt + 8'd1;
          end
        end
        LOW: begin
          if (div_last) begin
            state   <= SAMPLE;
            bit_cnt <= bit_cnt + 5'd1;
          end else begin
            div_cnt <= div_cnt + 8'd1;
          end
        end
        DONE: begin
          state           <= IDLE;
          raw_scan        <= raw_now;
          scan_done       <= 1'b1;
          buttons         <= buttons_next;
          buttons_changed <= |(buttons_next ^ buttons);
          for (int i = 0; i < NUM_BITS; i++) db_cnt[i] <= db_next[i];
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef DISPLAY_BUTTON_IRQ_EN
  logic [NUM_BITS-1:0] pressed_latch;
  logic [NUM_BITS-1:0] new_press;
  logic [NUM_BITS-1:0] latch_next;

  // A press landing on the ack cycle survives the clear.
  assign new_press  = (state == DONE) ? (buttons_next & ~buttons) : '0;
  assign latch_next = (irq_ack ? '0 : pressed_latch) | new_press;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pressed_latch <= '0;
      irq           <= 1'b0;
    end else begin
      pressed_latch <= latch_next;
      irq           <= |latch_next;
    end
  end
`endif

endmodule
